// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
//   md_state_t : FSM state encoding (IDLE, MULT, DIV, DIV_FIX, DONE)
//   MULT_LAT   : start-to-done latency of a MULT, in cycles
//   DIV_LAT    : start-to-done latency of a DIV with a non-zero divisor
//   booth_op_t : radix-2 Booth recoding of one multiplier bit pair
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MULT,
    MD_DIV,
    MD_DIV_FIX,
    MD_DONE
  } md_state_t;

  localparam int unsigned MULT_LAT = 33;
  localparam int unsigned DIV_LAT  = 34;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_t;

  // Radix-2 Booth: {current bit, previous bit} 01 -> +M, 10 -> -M, else none.
  function automatic booth_op_t booth_decode(input logic cur, input logic prev);
    booth_op_t op;
    op = BOOTH_NOP;
    if (cur && !prev) op = BOOTH_SUB;
    else if (!cur && prev) op = BOOTH_ADD;
    return op;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM and the mult/div unit.
//   mult_start, div_start : one-cycle operation requests (controller -> unit)
//   a, b                  : operands, sampled in the start cycle
//   hi, lo                : result registers (MULT product / DIV remainder,quotient)
//   busy                  : operation in flight
//   done                  : one-cycle completion pulse
//   zero_div              : divide-by-zero flag, pulses with done
// Modports: master = controller side, slave = unit side.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             zero_div;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, done, zero_div
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, done, zero_div
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit for the MIPS datapath.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; discards any in-flight operation
//   md    : slave side of mult_div_unit_if (starts, operands, hi/lo, busy,
//           done, zero_div)
// MULT is radix-2 Booth over a 2*WIDTH+1 accumulator, WIDTH cycles.
// DIV is restoring division on magnitudes, WIDTH cycles plus one sign-fix
// cycle. Both datapaths share the counter and the accumulator register.
// hi/lo are only written on entry to DONE and hold otherwise.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave md
);

  md_state_t          state;
  logic [CNT_W-1:0]   counter;
  // {upper: WIDTH+1 bits, lower: WIDTH bits}. MULT: partial product / multiplier.
  // DIV: partial remainder / dividend shifting into quotient.
  logic [2*WIDTH:0]   acc;
  logic               qm1;      // Booth "previous multiplier bit"
  logic [WIDTH-1:0]   opnd;     // multiplicand (MULT) or divisor magnitude (DIV)
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               zero_div_q;

  logic [WIDTH:0]     upper;
  logic [WIDTH-1:0]   lower;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH:0]   div_next;
  logic               last_step;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

  assign upper     = acc[2*WIDTH:WIDTH];
  assign lower     = acc[WIDTH-1:0];
  assign last_step = (counter == CNT_W'(WIDTH - 1));

  // Booth step: add/subtract the sign-extended multiplicand into the upper
  // part, then arithmetic-shift the whole accumulator right by one. The extra
  // upper bit keeps -2^(WIDTH-1) multiplicands from overflowing.
  always_comb begin
    booth_sum = upper;
    case (booth_decode(lower[0], qm1))
      BOOTH_ADD: booth_sum = upper + {opnd[WIDTH-1], opnd};
      BOOTH_SUB: booth_sum = upper - {opnd[WIDTH-1], opnd};
      default:   booth_sum = upper;
    endcase
    booth_next = {booth_sum[WIDTH], booth_sum, lower[WIDTH-1:1]};
  end

  // Restoring step: shift {remainder, dividend} left, trial-subtract the
  // divisor with one guard bit, keep the difference if it is non-negative.
  always_comb begin
    rem_sh = {upper[WIDTH-1:0], lower[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    if (!diff[WIDTH+1])
      div_next = {diff[WIDTH:0], lower[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_sh, lower[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MD_IDLE;
      counter    <= '0;
      acc        <= '0;
      qm1        <= 1'b0;
      opnd       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_div_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      zero_div_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (md.mult_start) begin
            opnd    <= md.a;
            acc     <= {{(WIDTH+1){1'b0}}, md.b};
            qm1     <= 1'b0;
            counter <= '0;
            busy_q  <= 1'b1;
            state   <= MD_MULT;
          end else if (md.div_start) begin
            busy_q <= 1'b1;
            if (md.b == '0) begin
              done_q     <= 1'b1;
              zero_div_q <= 1'b1;
              state      <= MD_DONE;
            end else begin
              opnd    <= cond_neg(md.b, md.b[WIDTH-1]);
              acc     <= {{(WIDTH+1){1'b0}}, cond_neg(md.a, md.a[WIDTH-1])};
              neg_q   <= md.a[WIDTH-1] ^ md.b[WIDTH-1];
              neg_r   <= md.a[WIDTH-1];
              counter <= '0;
              state   <= MD_DIV;
            end
          end
        end
        MD_MULT: begin
          acc     <= booth_next;
          qm1     <= lower[0];
          counter <= counter + CNT_W'(1);
          if (last_step) begin
            // hi/lo take the final step's result directly so they are valid
            // in the same cycle done rises.
            hi_q   <= booth_next[2*WIDTH-1:WIDTH];
            lo_q   <= booth_next[WIDTH-1:0];
            done_q <= 1'b1;
            state  <= MD_DONE;
          end
        end
        MD_DIV: begin
          acc     <= div_next;
          counter <= counter + CNT_W'(1);
          if (last_step) state <= MD_DIV_FIX;
        end
        MD_DIV_FIX: begin
          hi_q   <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
          lo_q   <= cond_neg(acc[WIDTH-1:0], neg_q);
          done_q <= 1'b1;
          state  <= MD_DONE;
        end
        MD_DONE: begin
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
      endcase
    end
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.zero_div = zero_div_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed MULT/DIV vectors
// with hand-computed results and latencies, plus hand-written sequences for
// divide-by-zero, simultaneous/overlapping starts and mid-operation reset.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mult_div_unit_if #(.WIDTH(32)) md_if ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zd;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request at edge N, optionally pulses div_start so it is
  // sampled at edge N+poke_at, and measures the cycle in which done is high
  // (cycle N+k is the period right after edge N+k-1). rtail reports whether
  // the cycle after done is back to idle with done/zero_div low.
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rzd, output logic rbusy, output logic rtail);
    lat   = 0;
    rbusy = 1'b0;
    rhi   = 'x;
    rlo   = 'x;
    rzd   = 1'bx;
    @(posedge clk);
    #1;
    md_if.mult_start = m;
    md_if.div_start  = d;
    md_if.a          = av;
    md_if.b          = bv;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      #1;
      md_if.mult_start = 1'b0;
      md_if.div_start  = (cyc == poke_at);
      md_if.a          = $urandom;
      md_if.b          = $urandom;
      @(negedge clk);
      if (cyc == 1) rbusy = md_if.busy;
      if (md_if.done) begin
        lat = cyc;
        rhi = md_if.hi;
        rlo = md_if.lo;
        rzd = md_if.zero_div;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    md_if.div_start = 1'b0;
    @(negedge clk);
    rtail = !md_if.done && !md_if.busy && !md_if.zero_div;
  endtask

  int          lat;
  logic [31:0] rhi;
  logic [31:0] rlo;
  logic        rzd;
  logic        rbusy;
  logic        rtail;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[5]  = '{1'b1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[7]  = '{1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
    vecs[8]  = '{1'b0, 32'd3,        32'd5,        32'h00000003, 32'h00000000, 1'b0, 34};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    vecs[10] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0, 33};
    vecs[11] = '{1'b0, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, 34};

    reset            = 1'b1;
    md_if.mult_start = 1'b0;
    md_if.div_start  = 1'b0;
    md_if.a          = '0;
    md_if.b          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", md_if.hi, 32'h0);
    check("reset_lo", md_if.lo, 32'h0);
    check("reset_busy", {31'b0, md_if.busy}, 32'h0);
    check("reset_done", {31'b0, md_if.done}, 32'h0);
    check("reset_zero_div", {31'b0, md_if.zero_div}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b, 0,
             lat, rhi, rlo, rzd, rbusy, rtail);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_hi", i), rhi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), rlo, vecs[i].lo);
      check($sformatf("vec%0d_zero_div", i), {31'b0, rzd}, {31'b0, vecs[i].zd});
      check($sformatf("vec%0d_busy", i), {31'b0, rbusy}, 32'h1);
      check($sformatf("vec%0d_idle_after", i), {31'b0, rtail}, 32'h1);
    end

    // Divide by zero: hi/lo keep the preceding MULT result.
    run_op(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 0, lat, rhi, rlo, rzd, rbusy, rtail);
    check("dz_preload_lo", rlo, 32'hFFFFFFEB);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, rhi, rlo, rzd, rbusy, rtail);
    check("dz_latency", 32'(lat), 32'd1);
    check("dz_zero_div", {31'b0, rzd}, 32'h1);
    check("dz_hi_kept", rhi, 32'hFFFFFFFF);
    check("dz_lo_kept", rlo, 32'hFFFFFFEB);
    check("dz_idle_after", {31'b0, rtail}, 32'h1);

    // Both starts together (mult wins), stray div_start at N+10 ignored.
    run_op(1'b1, 1'b1, 32'd6, 32'd7, 10, lat, rhi, rlo, rzd, rbusy, rtail);
    check("both_latency", 32'(lat), 32'd33);
    check("both_hi", rhi, 32'h0);
    check("both_lo", rlo, 32'd42);
    check("both_zero_div", {31'b0, rzd}, 32'h0);
    check("both_idle_after", {31'b0, rtail}, 32'h1);

    // Reset in cycle N+15 of a DIV.
    @(posedge clk);
    #1;
    md_if.div_start = 1'b1;
    md_if.a         = 32'hFFFFFFF9;
    md_if.b         = 32'd2;
    @(posedge clk);
    #1;
    md_if.div_start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    check("mid_busy_before_reset", {31'b0, md_if.busy}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_hi", md_if.hi, 32'h0);
    check("mid_reset_lo", md_if.lo, 32'h0);
    check("mid_reset_busy", {31'b0, md_if.busy}, 32'h0);
    check("mid_reset_done", {31'b0, md_if.done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, lat, rhi, rlo, rzd, rbusy, rtail);
    check("post_reset_latency", 32'(lat), 32'd33);
    check("post_reset_hi", rhi, 32'h0);
    check("post_reset_lo", rlo, 32'd12);
    check("post_reset_idle_after", {31'b0, rtail}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
